// File: rtl/ascon_pack.sv
// Shared types and round-index constants for the ASCON-128 permutation controller.
package ascon_pack;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AD_WAIT,
        S_AD_PERM,
        S_PT_WAIT,
        S_PT_PERM,
        S_FINAL,
        S_DONE
    } ctrl_state_t;

    localparam int DEF_ROUNDS_A = 12;
    localparam int DEF_ROUNDS_B = 6;

    // Round constants are indexed 0..11; shorter permutations start part-way in.
    function automatic logic [3:0] round_first(input int nbRounds);
        return 4'(12 - nbRounds);
    endfunction

    localparam logic [3:0] ROUND_FIRST_A = round_first(DEF_ROUNDS_A);
    localparam logic [3:0] ROUND_FIRST_B = round_first(DEF_ROUNDS_B);
    localparam logic [3:0] ROUND_LAST    = 4'd11;

endpackage

// File: rtl/ascon_perm_ctrl_round_counter.sv
// Round index counter: loads a start index and counts up to the last round, then holds.
module round_counter
    import ascon_pack::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_enable,
    output logic [3:0] o_round,
    output logic       o_last
);

    logic [3:0] r_count;

    // Saturates at the last round so an idle permutation state can never wrap the index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_enable && (r_count != ROUND_LAST)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_round = r_count;
    assign o_last  = (r_count == ROUND_LAST);

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Control FSM for one ASCON-128 job: init, AD absorb, PT/CT blocks, finalisation.
module ascon_perm_ctrl
    import ascon_pack::*;
#(
    parameter int NB_ROUNDS_A = DEF_ROUNDS_A,
    parameter int NB_ROUNDS_B = DEF_ROUNDS_B
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       decrypt_i,
    input  logic       has_ad_i,
    input  logic       blk_valid_i,
    input  logic       blk_last_i,
    output logic       blk_ready_o,
    output logic [3:0] round_o,
    output logic       sel_mux_perm_o,
    output logic       sel_muxData_perm_o,
    output logic       en_xor_begin_data_o,
    output logic       en_xor_begin_key_o,
    output logic       en_xor_end_lsb_o,
    output logic       en_xor_end_key_o,
    output logic       write_enable_data_o,
    output logic       write_enable_cipher_o,
    output logic       write_enable_tag_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       busy_o
);

    localparam logic [3:0] FIRST_A = round_first(NB_ROUNDS_A);
    localparam logic [3:0] FIRST_B = round_first(NB_ROUNDS_B);

    ctrl_state_t r_state;
    ctrl_state_t w_next;

    logic       r_decrypt;
    logic       r_hasAd;
    logic       r_adLast;
    logic       r_cipherValid;
    logic       r_tagValid;

    logic       w_inPerm;
    logic       w_nextPerm;
    logic       w_load;
    logic [3:0] w_loadVal;
    logic [3:0] w_round;
    logic       w_last;
    logic       w_first;

    assign w_inPerm   = (r_state == S_INIT) || (r_state == S_AD_PERM) ||
                        (r_state == S_PT_PERM) || (r_state == S_FINAL);
    assign w_nextPerm = (w_next == S_INIT) || (w_next == S_AD_PERM) ||
                        (w_next == S_PT_PERM) || (w_next == S_FINAL);

    // Permutation states are only ever entered from a non-permutation state.
    assign w_load    = w_nextPerm && !w_inPerm;
    assign w_loadVal = ((w_next == S_INIT) || (w_next == S_FINAL)) ? FIRST_A : FIRST_B;
    assign w_first   = ((r_state == S_INIT) || (r_state == S_FINAL)) ? (w_round == FIRST_A)
                                                                     : (w_round == FIRST_B);

    round_counter u_round_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_load),
        .i_load_val (w_loadVal),
        .i_enable   (w_inPerm),
        .o_round    (w_round),
        .o_last     (w_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_decrypt     <= 1'b0;
            r_hasAd       <= 1'b0;
            r_adLast      <= 1'b0;
            r_cipherValid <= 1'b0;
            r_tagValid    <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cipherValid <= write_enable_cipher_o;
            r_tagValid    <= write_enable_tag_o;
            if ((r_state == S_IDLE) && start_i) begin
                r_decrypt <= decrypt_i;
                r_hasAd   <= has_ad_i;
            end
            if ((r_state == S_AD_WAIT) && blk_valid_i) begin
                r_adLast <= blk_last_i;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_next = S_INIT;
            S_INIT:    if (w_last) w_next = r_hasAd ? S_AD_WAIT : S_PT_WAIT;
            S_AD_WAIT: if (blk_valid_i) w_next = S_AD_PERM;
            S_AD_PERM: if (w_last) w_next = r_adLast ? S_PT_WAIT : S_AD_WAIT;
            S_PT_WAIT: if (blk_valid_i) w_next = blk_last_i ? S_FINAL : S_PT_PERM;
            S_PT_PERM: if (w_last) w_next = S_PT_WAIT;
            S_FINAL:   if (w_last) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Moore decode of the datapath controls from state and round position.
    always_comb begin
        blk_ready_o           = 1'b0;
        sel_mux_perm_o        = 1'b0;
        sel_muxData_perm_o    = 1'b0;
        en_xor_begin_data_o   = 1'b0;
        en_xor_begin_key_o    = 1'b0;
        en_xor_end_lsb_o      = 1'b0;
        en_xor_end_key_o      = 1'b0;
        write_enable_data_o   = 1'b0;
        write_enable_cipher_o = 1'b0;
        write_enable_tag_o    = 1'b0;
        case (r_state)
            S_INIT: begin
                write_enable_data_o = 1'b1;
                sel_mux_perm_o      = !w_first;
                en_xor_end_key_o    = w_last;
                en_xor_end_lsb_o    = w_last && !r_hasAd;
            end
            S_AD_WAIT, S_PT_WAIT: begin
                blk_ready_o = 1'b1;
            end
            S_AD_PERM: begin
                write_enable_data_o = 1'b1;
                sel_mux_perm_o      = 1'b1;
                en_xor_begin_data_o = w_first;
                en_xor_end_lsb_o    = w_last && r_adLast;
            end
            S_PT_PERM: begin
                write_enable_data_o   = 1'b1;
                sel_mux_perm_o        = 1'b1;
                en_xor_begin_data_o   = w_first;
                write_enable_cipher_o = w_first;
                sel_muxData_perm_o    = w_first && r_decrypt;
            end
            S_FINAL: begin
                write_enable_data_o   = 1'b1;
                sel_mux_perm_o        = 1'b1;
                en_xor_begin_data_o   = w_first;
                en_xor_begin_key_o    = w_first;
                write_enable_cipher_o = w_first;
                sel_muxData_perm_o    = w_first && r_decrypt;
                en_xor_end_key_o      = w_last;
                write_enable_tag_o    = w_last;
            end
            default: ;
        endcase
    end

    assign round_o        = w_inPerm ? w_round : 4'd0;
    assign cipher_valid_o = r_cipherValid;
    assign tag_valid_o    = r_tagValid;
    assign busy_o         = (r_state != S_IDLE);

endmodule
